xpb_table_gen: RTL



---
 rtl/xpb_table_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/xpb_table_gen.sv
// Generates the table entry[k] = k*B mod N for k = 0..2^DIGIT_BITS-1 by modular accumulation.
// Optional XPB_GEN_BASE_DOUBLE_EN: B is derived internally as 2^SHIFT mod N instead of taken from base_in.
module xpb_table_gen #(
  parameter int unsigned WIDTH      = 1024,
  parameter int unsigned DIGIT_BITS = 5,
  parameter int unsigned SHIFT      = 240
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      modulus,
  input  logic [WIDTH-1:0]      base_in,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_en,
  output logic [DIGIT_BITS-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data,
  input  logic                  wr_ready
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    ADD,
    SUB,
    BASE_ADD,
    BASE_SUB
  } state_t;

  localparam logic [DIGIT_BITS-1:0] LAST_K = {DIGIT_BITS{1'b1}};

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum_q;

`ifdef XPB_GEN_BASE_DOUBLE_EN
  localparam int unsigned CNT_W = $clog2(SHIFT + 2);
  logic [CNT_W-1:0] dbl_cnt;
`endif

  // Since both operands are below N, the sum is below 2N and one subtract reduces it.
  function automatic logic [WIDTH-1:0] cond_sub(input logic [WIDTH:0] s, input logic [WIDTH-1:0] n);
    if (s >= {1'b0, n}) return WIDTH'(s - {1'b0, n});
    else                return s[WIDTH-1:0];
  endfunction

  // wr_addr and wr_data double as the digit counter k and the accumulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      n_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
`ifdef XPB_GEN_BASE_DOUBLE_EN
      dbl_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q     <= modulus;
            wr_addr <= '0;
            wr_data <= '0;
            busy    <= 1'b1;
`ifdef XPB_GEN_BASE_DOUBLE_EN
            b_q     <= WIDTH'(1);
            dbl_cnt <= '0;
            if (SHIFT == 0) begin
              state <= WRITE;
              wr_en <= 1'b1;
            end else begin
              state <= BASE_ADD;
            end
`else
            b_q   <= base_in;
            state <= WRITE;
            wr_en <= 1'b1;
`endif
          end
        end
        WRITE: begin
          if (wr_ready) begin
            wr_en <= 1'b0;
            if (wr_addr == LAST_K) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= ADD;
            end
          end
        end
        ADD: begin
          sum_q   <= {1'b0, wr_data} + {1'b0, b_q};
          wr_addr <= wr_addr + DIGIT_BITS'(1);
          state   <= SUB;
        end
        SUB: begin
          wr_data <= cond_sub(sum_q, n_q);
          wr_en   <= 1'b1;
          state   <= WRITE;
        end
`ifdef XPB_GEN_BASE_DOUBLE_EN
        BASE_ADD: begin
          sum_q <= {1'b0, b_q} + {1'b0, b_q};
          state <= BASE_SUB;
        end
        BASE_SUB: begin
          b_q     <= cond_sub(sum_q, n_q);
          dbl_cnt <= dbl_cnt + CNT_W'(1);
          if (dbl_cnt == CNT_W'(SHIFT - 1)) begin
            state <= WRITE;
            wr_en <= 1'b1;
          end else begin
            state <= BASE_ADD;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
